alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 48 ++++
 rtl/alu_seq_alu8.sv | 68 ++++++
 rtl/alu_seq.sv | 129 ++++++++++++
 tb/tb_alu_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Opcodes, flag bit positions and FSM states shared by
// the byte-serial ALU and its 8-bit per-byte engine.
package alu_seq_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_ADC  = 5'b00001;
   localparam logic [4:0] OP_SUB  = 5'b00010;
   localparam logic [4:0] OP_SBC  = 5'b00011;
   localparam logic [4:0] OP_CP   = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_XOR  = 5'b00111;
   localparam logic [4:0] OP_INC  = 5'b10111;
   localparam logic [4:0] OP_DEC  = 5'b11000;
   localparam logic [4:0] OP_ADDW = 5'b11001;

   localparam int F_Z = 7;
   localparam int F_N = 6;
   localparam int F_H = 5;
   localparam int F_C = 4;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   function automatic logic is_add(input logic [4:0] op);
      return op inside {OP_ADD, OP_ADC, OP_INC, OP_ADDW};
   endfunction

   function automatic logic is_sub(input logic [4:0] op);
      return op inside {OP_SUB, OP_SBC, OP_CP, OP_DEC};
   endfunction

   function automatic logic is_logic(input logic [4:0] op);
      return op inside {OP_AND, OP_OR, OP_XOR};
   endfunction

   function automatic logic is_incdec(input logic [4:0] op);
      return op inside {OP_INC, OP_DEC};
   endfunction

   // INC/DEC are built as +/- 0 with a forced carry-in
   function automatic logic first_cin(input logic [4:0] op,
                                      input logic [7:0] f);
      if (op == OP_ADC || op == OP_SBC) return f[F_C];
      if (is_incdec(op)) return 1'b1;
      return 1'b0;
   endfunction

endpackage

// File: rtl/alu_seq_alu8.sv
// Combinational 8-bit ALU used as the per-byte engine
// of alu_seq; carry enters and leaves through flag bit C.
module alu8
   import alu_seq_pkg::*;
(
   input  logic [4:0] opcode,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] flagsIn,
   output logic [7:0] res,
   output logic [7:0] flagsOut
);

   logic       cin;
   logic       h;
   logic       c;
   logic       n;
   logic       pass;
   logic [7:0] val;
   logic [3:0] unused_nib;
   logic       unused_lo;

   assign unused_lo = ^flagsIn[3:0];

   always_comb begin
      cin = (opcode == OP_ADC || opcode == OP_SBC) ?
            flagsIn[F_C] : 1'b0;
      val        = a;
      res        = a;
      h          = 1'b0;
      c          = 1'b0;
      n          = 1'b0;
      pass       = 1'b0;
      unused_nib = '0;
      unique case (opcode)
         OP_ADD, OP_ADC: begin
            {c, val} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            {h, unused_nib} = {1'b0, a[3:0]} + {1'b0, b[3:0]}
                              + {4'd0, cin};
            res = val;
         end
         OP_SUB, OP_SBC, OP_CP: begin
            {c, val} = {1'b0, a} - {1'b0, b} - {8'd0, cin};
            {h, unused_nib} = {1'b0, a[3:0]} - {1'b0, b[3:0]}
                              - {4'd0, cin};
            n   = 1'b1;
            res = (opcode == OP_CP) ? a : val;
         end
         OP_AND: begin
            val = a & b;
            h   = 1'b1;
            res = val;
         end
         OP_OR: begin
            val = a | b;
            res = val;
         end
         OP_XOR: begin
            val = a ^ b;
            res = val;
         end
         default: pass = 1'b1;
      endcase
      flagsOut = {val == 8'd0, n, h, c, 4'b0000};
      if (pass) flagsOut = {flagsIn[7:4], 4'b0000};
   end

endmodule

// File: rtl/alu_seq.sv
// Byte-serial ALU: one alu8 pass per byte, LSB first,
// with a valid/ready request side and a held result side.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int DATA_W = 16
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        opcode,
   input  logic [DATA_W-1:0] regA,
   input  logic [DATA_W-1:0] regB,
   input  logic [7:0]        flagsIn,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] res,
   output logic [7:0]        flagsOut
);

   localparam int NBYTES = DATA_W / 8;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   state_t            state;
   state_t            state_n;
   logic [4:0]        op;
   logic [DATA_W-1:0] a_sh;
   logic [DATA_W-1:0] b_sh;
   logic [3:0]        f_hi;
   logic [IW-1:0]     idx;
   logic              carry;
   logic              zacc;
   logic              last;
   logic              known;
   logic              pass_a;
   logic              z_n;
   logic [4:0]        eng_op;
   logic [7:0]        eng_res;
   logic [7:0]        eng_flags;
   logic [7:0]        byte_res;
   logic [7:0]        flags_n;
   logic              unused_bits;

   assign unused_bits = ^{flagsIn[3:0], eng_flags[3:0]};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (in_valid)  state_n = BUSY;
         BUSY:    if (last)      state_n = DONE;
         DONE:    if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   always_comb begin
      last   = (idx == IW'(NBYTES - 1));
      known  = is_add(op) || is_sub(op) || is_logic(op);
      pass_a = !known || (op == OP_CP);
      unique case (1'b1)
         is_sub(op):   eng_op = OP_SBC;
         is_logic(op): eng_op = op;
         default:      eng_op = OP_ADC;
      endcase
   end

   alu8 u_alu8 (
      .opcode   (eng_op),
      .a        (a_sh[7:0]),
      .b        (b_sh[7:0]),
      .flagsIn  ({3'b000, carry, 4'b0000}),
      .res      (eng_res),
      .flagsOut (eng_flags)
   );

   always_comb begin
      byte_res = pass_a ? a_sh[7:0] : eng_res;
      z_n      = zacc & eng_flags[F_Z];
      flags_n  = {z_n, eng_flags[F_N], eng_flags[F_H],
                  eng_flags[F_C], 4'b0000};
      if (op == OP_ADDW)  flags_n[F_Z] = f_hi[F_Z-4];
      if (is_incdec(op))  flags_n[F_C] = f_hi[F_C-4];
      if (!known)         flags_n = {f_hi, 4'b0000};
   end

   // Operands shift right so the active byte is always [7:0]
   always_ff @(posedge clk) begin
      if (rst) begin
         op       <= OP_ADD;
         a_sh     <= '0;
         b_sh     <= '0;
         f_hi     <= '0;
         idx      <= '0;
         carry    <= 1'b0;
         zacc     <= 1'b0;
         res      <= '0;
         flagsOut <= '0;
      end else if (state == IDLE && in_valid) begin
         op    <= opcode;
         a_sh  <= regA;
         b_sh  <= is_incdec(opcode) ? '0 : regB;
         f_hi  <= flagsIn[7:4];
         idx   <= '0;
         carry <= first_cin(opcode, flagsIn);
         zacc  <= 1'b1;
      end else if (state == BUSY) begin
         a_sh  <= a_sh >> 8;
         b_sh  <= b_sh >> 8;
         idx   <= idx + 1'b1;
         carry <= eng_flags[F_C];
         zacc  <= z_n;
         res   <= (res >> 8) | (DATA_W'(byte_res) << (DATA_W - 8));
         if (last) flagsOut <= flags_n;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at DATA_W = 8, 16 and 32
// against a full-width arithmetic reference model.
module tb_alu_seq;
   import alu_seq_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [4:0]  opcode   = '0;
   logic [31:0] reg_a    = '0;
   logic [31:0] reg_b    = '0;
   logic [7:0]  flags_in = '0;
   logic        out_ready = 1'b0;
   logic        iv8 = 1'b0, iv16 = 1'b0, iv32 = 1'b0;
   logic        ir8, ir16, ir32;
   logic        ov8, ov16, ov32;
   logic [7:0]  r8;
   logic [15:0] r16;
   logic [31:0] r32;
   logic [7:0]  fo8, fo16, fo32;

   int sel = 16;
   logic        cur_ready, cur_valid;
   logic [31:0] cur_res;
   logic [7:0]  cur_flags;

   int checks = 0;
   int errors = 0;
   logic [39:0] sb_q[$];

   alu_seq #(.DATA_W(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
      .opcode(opcode), .regA(reg_a[7:0]), .regB(reg_b[7:0]),
      .flagsIn(flags_in), .out_valid(ov8), .out_ready(out_ready),
      .res(r8), .flagsOut(fo8));

   alu_seq #(.DATA_W(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
      .opcode(opcode), .regA(reg_a[15:0]), .regB(reg_b[15:0]),
      .flagsIn(flags_in), .out_valid(ov16), .out_ready(out_ready),
      .res(r16), .flagsOut(fo16));

   alu_seq #(.DATA_W(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
      .opcode(opcode), .regA(reg_a), .regB(reg_b),
      .flagsIn(flags_in), .out_valid(ov32), .out_ready(out_ready),
      .res(r32), .flagsOut(fo32));

   always_comb begin
      case (sel)
         8: begin
            cur_ready = ir8;  cur_valid = ov8;
            cur_res = {24'd0, r8};  cur_flags = fo8;
         end
         32: begin
            cur_ready = ir32; cur_valid = ov32;
            cur_res = r32;  cur_flags = fo32;
         end
         default: begin
            cur_ready = ir16; cur_valid = ov16;
            cur_res = {16'd0, r16}; cur_flags = fo16;
         end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [39:0] model(input int w,
                                         input logic [4:0] op,
                                         input logic [31:0] ai,
                                         input logic [31:0] bi,
                                         input logic [7:0] f);
      logic [32:0] m, lm, a, b, s, lo;
      logic [31:0] r;
      logic z, n, h, c, cin;
      int hb;
      m  = (33'd1 << w) - 33'd1;
      hb = w - 4;
      lm = (33'd1 << hb) - 33'd1;
      a  = {1'b0, ai} & m;
      b  = {1'b0, bi} & m;
      n = 1'b0; h = 1'b0; c = 1'b0;
      cin = (op == OP_ADC || op == OP_SBC) ? f[4] : 1'b0;
      if (op == OP_INC || op == OP_DEC) b = 33'd1;
      r = ai & m[31:0];
      if (is_add(op)) begin
         s  = a + b + {32'd0, cin};
         lo = (a & lm) + (b & lm) + {32'd0, cin};
         r = s[31:0] & m[31:0]; c = s[w]; h = lo[hb];
      end else if (is_sub(op)) begin
         s  = a - b - {32'd0, cin};
         lo = (a & lm) - (b & lm) - {32'd0, cin};
         r = s[31:0] & m[31:0]; c = s[w]; h = lo[hb]; n = 1'b1;
      end else if (op == OP_AND) begin
         r = ai & bi & m[31:0]; h = 1'b1;
      end else if (op == OP_OR) begin
         r = (ai | bi) & m[31:0];
      end else if (op == OP_XOR) begin
         r = (ai ^ bi) & m[31:0];
      end else begin
         return {ai & m[31:0], f[7:4], 4'b0000};
      end
      z = (r == 32'd0);
      if (op == OP_CP) r = ai & m[31:0];
      if (op == OP_INC || op == OP_DEC) c = f[4];
      if (op == OP_ADDW) z = f[7];
      return {r, z, n, h, c, 4'b0000};
   endfunction

   // Pop on a handshake seen half a cycle before the taking edge
   always @(negedge clk) begin
      if (!rst && cur_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected", 32'd1, 32'd0);
         end else begin
            logic [39:0] e;
            e = sb_q.pop_front();
            check("res", cur_res, e[39:8]);
            check("flags", {24'd0, cur_flags}, {24'd0, e[7:0]});
         end
      end
   end

   task automatic drive_iv(input logic v);
      iv8  = (sel == 8)  ? v : 1'b0;
      iv16 = (sel == 16) ? v : 1'b0;
      iv32 = (sel == 32) ? v : 1'b0;
   endtask

   task automatic issue(input int w, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] f, input logic [39:0] exp,
                        input int hold);
      int n;
      sel = w;
      opcode = op; reg_a = a; reg_b = b; flags_in = f;
      drive_iv(1'b1);
      n = 0;
      while (!cur_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("ready_wait", {31'd0, cur_ready}, 32'd1);
      @(posedge clk);
      sb_q.push_back(exp);
      #1 drive_iv(1'b0);
      n = 0;
      while (!cur_valid && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("latency", n, w / 8);
      if (hold > 0) begin
         opcode = OP_XOR; reg_a = $urandom; reg_b = $urandom;
         drive_iv(1'b1);
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("stall_valid", {31'd0, cur_valid}, 32'd1);
            check("stall_ready", {31'd0, cur_ready}, 32'd0);
            check("stall_res", cur_res, exp[39:8]);
            check("stall_flags", {24'd0, cur_flags}, {24'd0, exp[7:0]});
         end
         drive_iv(1'b0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (hold > 0) begin
         check("idle_ready", {31'd0, cur_ready}, 32'd1);
         check("idle_valid", {31'd0, cur_valid}, 32'd0);
      end
   endtask

   initial begin
      logic [4:0] ops[13];
      logic [4:0] op8[5];
      int seen;
      ops = '{OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP, OP_AND, OP_OR,
              OP_XOR, OP_INC, OP_DEC, OP_ADDW, 5'b01010, 5'b11111};
      op8 = '{OP_ADC, OP_SBC, OP_AND, OP_OR, OP_XOR};

      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         sel = 8 << k;
         #1;
         check("rst_ready", {31'd0, cur_ready}, 32'd1);
         check("rst_valid", {31'd0, cur_valid}, 32'd0);
         check("rst_res", cur_res, 32'd0);
         check("rst_flags", {24'd0, cur_flags}, 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      issue(16, OP_ADD,  32'h0FFF, 32'h0001, 8'h00, {32'h1000, 8'h20}, 0);
      issue(16, OP_SUB,  32'h1000, 32'h0001, 8'h00, {32'h0FFF, 8'h60}, 0);
      issue(16, OP_CP,   32'h1000, 32'h0001, 8'h00, {32'h1000, 8'h60}, 0);
      issue(16, OP_ADDW, 32'hFFFF, 32'h0001, 8'h00, {32'h0000, 8'h30}, 0);
      issue(16, OP_DEC,  32'h0000, 32'h1234, 8'h10, {32'hFFFF, 8'h70}, 0);
      issue(16, OP_AND,  32'hF0F0, 32'h0FF0, 8'h00, {32'h00F0, 8'h20}, 3);

      sel = 16;
      opcode = OP_ADC; reg_a = 32'h00FF; reg_b = 32'h0001;
      flags_in = 8'h00;
      drive_iv(1'b1);
      @(posedge clk); #1;
      drive_iv(1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_ready", {31'd0, cur_ready}, 32'd1);
      check("mid_rst_valid", {31'd0, cur_valid}, 32'd0);
      check("mid_rst_res", cur_res, 32'd0);
      check("mid_rst_flags", {24'd0, cur_flags}, 32'd0);
      seen = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (cur_valid) seen++;
      end
      check("mid_rst_no_valid", seen, 0);

      issue(32, OP_ADC, 32'hFFFF_FFFF, 32'h0, 8'h10,
            {32'h0000_0000, 8'hB0}, 0);

      for (int i = 0; i < 100; i++) begin
         logic [4:0]  op;
         logic [31:0] a, b;
         logic [7:0]  f;
         op = op8[$urandom_range(0, 4)];
         a = {24'd0, 8'($urandom)};
         b = {24'd0, 8'($urandom)};
         f = {8'($urandom)} & 8'hF0;
         issue(8, op, a, b, f, model(8, op, a, b, f), 0);
      end

      for (int i = 0; i < 30; i++) begin
         logic [4:0]  op;
         logic [31:0] a, b;
         logic [7:0]  f;
         op = ops[$urandom_range(0, 12)];
         a = {16'd0, 16'($urandom)};
         b = {16'd0, 16'($urandom)};
         f = 8'($urandom);
         issue(16, op, a, b, f, model(16, op, a, b, f), i % 7 == 0 ? 1 : 0);
      end

      issue(16, OP_INC, 32'h000F, 32'hFFFF, 8'h10,
            model(16, OP_INC, 32'h000F, 32'hFFFF, 8'h10), 0);
      issue(32, OP_SBC, 32'h1000_0000, 32'h0000_0001, 8'h10,
            model(32, OP_SBC, 32'h1000_0000, 32'h0000_0001, 8'h10), 0);

      repeat (3) @(posedge clk);
      check("sb_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
